// File: rtl/serial_word_pkg.sv
// Package: serial_word_pkg
// Shared definitions for the serial word receive path: FSM state type,
// default word width (matches the parallel-load shifter on the transmit
// side) and the bit-counter width helper.
package serial_word_pkg;

  // Default word width shared with the right-shifting parallel-load shifter.
  localparam int WORD_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the bit counter for an n-bit word (counts 0..n-1).
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Interface: serial_word_deserializer_if
// Bundles the serial input strobe group and the valid/ready word output.
//   sin, sin_valid, frame_start : serial bit, bit strobe, word-alignment marker
//   out_data, out_valid         : assembled word and its valid flag
//   out_ready                   : consumer accepts out_data when out_valid && out_ready
// master = the environment (bit source and word consumer), slave = the deserializer.
interface serial_word_deserializer_if import serial_word_pkg::*; #(
  parameter int N = WORD_W
);
  logic         sin;
  logic         sin_valid;
  logic         frame_start;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output sin, sin_valid, frame_start, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  sin, sin_valid, frame_start, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/serial_word_out_reg.sv
// Module: serial_word_out_reg
// One-deep valid/ready holding register for completed words.
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : a completed word is offered this cycle
//   push_data    : the completed word
//   pop          : consumer ready (acts only while valid)
//   flag_clr     : synchronous clear of overrun
//   data, valid  : held word and its valid flag
//   overrun      : sticky, a pushed word was dropped because the register was full
module serial_word_out_reg import serial_word_pkg::*; #(
  parameter int N = WORD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  input  logic         flag_clr,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         overrun
);

  logic load;
  logic drop;

  // Decide whether an offered word lands or is dropped; a pop in the same
  // cycle frees the slot so the new word replaces the old one.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    if (push) begin
      load = !valid || pop;
      drop = valid && !pop;
    end else begin
      load = 1'b0;
      drop = 1'b0;
    end
  end

  // Holding register, valid flag and sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data    <= {N{1'b0}};
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        data  <= push_data;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (flag_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Module: serial_word_deserializer
// LSB-first serial-in / parallel-out receive stage. Assembles N-bit words
// aligned to frame_start and hands them to a one-deep valid/ready register.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : sin/sin_valid/frame_start in, out_data/out_valid out, out_ready in
//   busy         : partial word in progress
//   overrun      : sticky, completed word dropped because the output was full
//   frame_err    : sticky, frame_start arrived mid-word (partial word discarded)
//   flag_clr     : synchronous clear of overrun and frame_err
module serial_word_deserializer import serial_word_pkg::*; #(
  parameter int N          = WORD_W,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  serial_word_deserializer_if.slave    bus,
  output logic                         busy,
  output logic                         overrun,
  output logic                         frame_err,
  input  logic                         flag_clr
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  // Only the latest N-1 bits are stored: on the completing edge bit 0 leaves
  // the shift path and goes straight into the output register.
  logic [N-2:0]  hold;
  logic [N-2:0]  hold_next;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_next;
  logic [N-1:0]  word;
  logic          push;
  logic          ferr_set;
  logic          busy_next;

  // Next-state, shift and completion decode.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    cnt_next   = bit_cnt;
    push       = 1'b0;
    ferr_set   = 1'b0;
    word       = {bus.sin, hold};
    case (state)
      IDLE: begin
        if (bus.sin_valid && bus.frame_start) begin
          hold_next  = word[N-1:1];
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          hold_next = word[N-1:1];
          if (bus.frame_start && (bit_cnt != {CW{1'b0}})) begin
            // Realign: the partial word is abandoned, this bit is bit 0.
            ferr_set = 1'b1;
            cnt_next = CW'(1);
          end else if (bit_cnt == LAST) begin
            push       = 1'b1;
            cnt_next   = {CW{1'b0}};
            state_next = CONTINUOUS ? SHIFT : IDLE;
          end else begin
            cnt_next = bit_cnt + CW'(1);
          end
        end else begin
          state_next = SHIFT;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {CW{1'b0}};
      end
    endcase
    busy_next = (state_next == SHIFT) && ((cnt_next != {CW{1'b0}}) || !CONTINUOUS);
  end

  // FSM, shifter, bit counter, busy and sticky frame error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold      <= {(N-1){1'b0}};
      bit_cnt   <= {CW{1'b0}};
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state   <= state_next;
      hold    <= hold_next;
      bit_cnt <= cnt_next;
      busy    <= busy_next;
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (flag_clr) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
    end
  end

  serial_word_out_reg #(.N(N)) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (word),
    .pop       (bus.out_ready),
    .flag_clr  (flag_clr),
    .data      (bus.out_data),
    .valid     (bus.out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench: dut0 is N=4 / CONTINUOUS=0, dut1 is N=8 / CONTINUOUS=1.
module tb_serial_word_deserializer;
  import serial_word_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial_word_deserializer_if #(.N(4)) bus0 ();
  serial_word_deserializer_if #(.N(8)) bus1 ();

  logic busy0, ov0, fe0, clr0;
  logic busy1, ov1, fe1, clr1;

  serial_word_deserializer #(.N(4), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .busy(busy0), .overrun(ov0), .frame_err(fe0), .flag_clr(clr0)
  );

  serial_word_deserializer #(.N(8), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .busy(busy1), .overrun(ov1), .frame_err(fe1), .flag_clr(clr1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for dut0: list of collected bits plus an output slot.
  bit       m_in_word;
  int       m_pos;
  int       m_bits [4];
  logic [3:0] m_od;
  bit       m_ov;
  bit       m_overrun;
  bit       m_ferr;

  task automatic model_reset();
    m_in_word = 1'b0; m_pos = 0; m_od = 4'h0; m_ov = 1'b0;
    m_overrun = 1'b0; m_ferr = 1'b0;
    for (int i = 0; i < 4; i++) m_bits[i] = 0;
  endtask

  task automatic model_step(input logic v, input logic fs, input logic s,
                            input logic rdy, input logic clr);
    bit done = 1'b0;
    bit fe_set = 1'b0;
    bit ov_set = 1'b0;
    int w = 0;
    if (v) begin
      if (fs) begin
        if (m_in_word) fe_set = 1'b1;
        m_bits[0] = int'(s); m_pos = 1; m_in_word = 1'b1;
      end else if (m_in_word) begin
        m_bits[m_pos] = int'(s);
        m_pos++;
        if (m_pos == 4) begin
          done = 1'b1; m_pos = 0; m_in_word = 1'b0;
          for (int i = 0; i < 4; i++) w += m_bits[i] * (1 << i);
        end
      end
    end
    if (done) begin
      if (!m_ov || rdy) begin m_od = 4'(w); m_ov = 1'b1; end
      else ov_set = 1'b1;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (ov_set) m_overrun = 1'b1; else if (clr) m_overrun = 1'b0;
    if (fe_set) m_ferr = 1'b1; else if (clr) m_ferr = 1'b0;
  endtask

  // One clock on dut0 with the given inputs; model follows the same edge.
  task automatic tick0(input logic v, input logic fs, input logic s,
                       input logic rdy, input logic clr);
    bus0.sin_valid = v; bus0.frame_start = fs; bus0.sin = s;
    bus0.out_ready = rdy; clr0 = clr;
    @(posedge clk); #1;
    model_step(v, fs, s, rdy, clr);
  endtask

  task automatic send_word0(input logic [3:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) tick0(1'b1, i == 0, w[i], rdy, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus0.sin_valid = 1'($urandom); bus0.frame_start = 1'($urandom);
      bus0.sin = 1'($urandom); bus0.out_ready = 1'($urandom); clr0 = 1'($urandom);
      bus1.sin_valid = 1'($urandom); bus1.frame_start = 1'($urandom);
      bus1.sin = 1'($urandom); bus1.out_ready = 1'($urandom); clr1 = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.out_data, busy0, ov0, fe0} !== 8'h00) begin
        errors++;
        $display("FAIL reset_dut0: got %b expected 00000000",
                 {bus0.out_valid, bus0.out_data, busy0, ov0, fe0});
      end
      checks++;
      if ({bus1.out_valid, bus1.out_data, busy1, ov1, fe1} !== 12'h000) begin
        errors++;
        $display("FAIL reset_dut1: got %b expected 000000000000",
                 {bus1.out_valid, bus1.out_data, busy1, ov1, fe1});
      end
    end
    bus1.sin_valid = 1'b0; bus1.frame_start = 1'b0; bus1.sin = 1'b0;
    bus1.out_ready = 1'b0; clr1 = 1'b0;
    bus0.sin_valid = 1'b1; bus0.frame_start = 1'b0;
    reset_n = 1'b1;
    model_reset();
    // Mid-stream bits without frame_start must not start a word.
    for (int c = 0; c < 6; c++) begin
      tick0(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
      checks++;
      if ({bus0.out_valid, busy0} !== 2'b00) begin
        errors++;
        $display("FAIL release_idle: got valid,busy=%b expected 00",
                 {bus0.out_valid, busy0});
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] d = 4'hD;
    for (int i = 0; i < 4; i++) begin
      tick0(1'b1, i == 0, d[i], 1'b1, 1'b0);
      if (i < 3) begin
        checks++;
        if ({busy0, bus0.out_valid} !== 2'b10) begin
          errors++;
          $display("FAIL basic_busy bit%0d: got busy,valid=%b expected 10", i,
                   {busy0, bus0.out_valid});
        end
      end
    end
    checks++;
    if ({bus0.out_valid, bus0.out_data, busy0} !== 6'b1_1101_0) begin
      errors++;
      $display("FAIL basic_word: got valid,data,busy=%b expected 111010",
               {bus0.out_valid, bus0.out_data, busy0});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: got valid=%b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] d = 4'hD;
    for (int i = 0; i < 4; i++) begin
      tick0(1'b1, i == 0, d[i], 1'b1, 1'b0);
      if (i < 3) begin
        tick0(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick0(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({busy0, bus0.out_valid} !== 2'b10) begin
          errors++;
          $display("FAIL gaps_busy bit%0d: got busy,valid=%b expected 10", i,
                   {busy0, bus0.out_valid});
        end
      end
    end
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== 5'b1_1101) begin
      errors++;
      $display("FAIL gaps_word: got valid,data=%b expected 11101",
               {bus0.out_valid, bus0.out_data});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word0(4'h3, 1'b0);
    checks++;
    if ({bus0.out_valid, bus0.out_data, ov0} !== 6'b1_0011_0) begin
      errors++;
      $display("FAIL ovr_first: got valid,data,ovr=%b expected 100110",
               {bus0.out_valid, bus0.out_data, ov0});
    end
    send_word0(4'hA, 1'b0);
    checks++;
    if ({bus0.out_valid, bus0.out_data, ov0} !== 6'b1_0011_1) begin
      errors++;
      $display("FAIL ovr_drop: got valid,data,ovr=%b expected 100111",
               {bus0.out_valid, bus0.out_data, ov0});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus0.out_valid, bus0.out_data, ov0} !== 6'b1_0011_0) begin
      errors++;
      $display("FAIL ovr_clr: got valid,data,ovr=%b expected 100110",
               {bus0.out_valid, bus0.out_data, ov0});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pop: got valid=%b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_framing();
    tick0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word0(4'h6, 1'b0);
    checks++;
    if ({fe0, bus0.out_valid, bus0.out_data, ov0} !== 7'b1_1_0110_0) begin
      errors++;
      $display("FAIL frame_word: got ferr,valid,data,ovr=%b expected 1101100",
               {fe0, bus0.out_valid, bus0.out_data, ov0});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({fe0, bus0.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL frame_clr: got ferr,valid=%b expected 00", {fe0, bus0.out_valid});
    end
    // Framing error in the same cycle as flag_clr: the set wins.
    tick0(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick0(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (fe0 !== 1'b1) begin
      errors++;
      $display("FAIL frame_set_wins: got ferr=%b expected 1", fe0);
    end
    tick0(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick0(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick0(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== 5'b1_0110) begin
      errors++;
      $display("FAIL frame_realign: got valid,data=%b expected 10110",
               {bus0.out_valid, bus0.out_data});
    end
    tick0(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_continuous();
    logic [7:0] sr = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) sr = 8'h3C;
      bus1.sin = sr[0]; bus1.sin_valid = 1'b1; bus1.frame_start = (i == 0);
      bus1.out_ready = (i == 15); clr1 = 1'b0;
      tick0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sr = {1'b0, sr[7:1]};
      if (i == 3) begin
        checks++;
        if (busy1 !== 1'b1) begin
          errors++;
          $display("FAIL cont_busy: got %b expected 1", busy1);
        end
      end
      if (i == 7 || i == 14) begin
        checks++;
        if ({bus1.out_valid, bus1.out_data} !== 9'h1A5) begin
          errors++;
          $display("FAIL cont_first bit%0d: got valid,data=%h expected 1a5", i,
                   {bus1.out_valid, bus1.out_data});
        end
      end
    end
    checks++;
    if ({bus1.out_valid, bus1.out_data, ov1, fe1, busy1} !== 12'b1_0011_1100_000) begin
      errors++;
      $display("FAIL cont_second: got valid,data,ovr,ferr,busy=%b expected 100111100000",
               {bus1.out_valid, bus1.out_data, ov1, fe1, busy1});
    end
    bus1.sin_valid = 1'b0; bus1.frame_start = 1'b0; bus1.out_ready = 1'b1;
    tick0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cont_pop: got valid=%b expected 0", bus1.out_valid);
    end
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick0(($urandom % 4) != 0, ($urandom % 6) == 0, 1'($urandom),
            ($urandom % 3) != 0, ($urandom % 16) == 0);
      checks++;
      if (bus0.out_valid !== m_ov) begin
        errors++;
        $display("FAIL rand_valid cyc%0d: got %b expected %b", c, bus0.out_valid, m_ov);
      end
      checks++;
      if (bus0.out_data !== m_od) begin
        errors++;
        $display("FAIL rand_data cyc%0d: got %h expected %h", c, bus0.out_data, m_od);
      end
      checks++;
      if (busy0 !== m_in_word) begin
        errors++;
        $display("FAIL rand_busy cyc%0d: got %b expected %b", c, busy0, m_in_word);
      end
      checks++;
      if (ov0 !== m_overrun) begin
        errors++;
        $display("FAIL rand_overrun cyc%0d: got %b expected %b", c, ov0, m_overrun);
      end
      checks++;
      if (fe0 !== m_ferr) begin
        errors++;
        $display("FAIL rand_ferr cyc%0d: got %b expected %b", c, fe0, m_ferr);
      end
    end
  endtask

  initial begin
    bus0.sin = 1'b0; bus0.sin_valid = 1'b0; bus0.frame_start = 1'b0; bus0.out_ready = 1'b0;
    bus1.sin = 1'b0; bus1.sin_valid = 1'b0; bus1.frame_start = 1'b0; bus1.out_ready = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_framing();
    test_continuous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
